dac_spi_serializer: RTL

Downstream consumer of the wave generator's output sample stream. It converts each signed Q0.N_FRAC sample into offset-binary and frames it with a fixed command nibble into a 16-bit word. The word is shifted out MSB-first over a mode-0 SPI link to an external DAC. A one-deep holding register absorbs a sample that arrives while a frame is in flight; any further sample before that slot frees up is flagged as overflow.

---
 rtl/dac_spi_serializer_pkg.sv | 19 +
 rtl/dac_frame_shifter.sv | 103 ++++++++++
 rtl/dac_spi_serializer.sv | 80 ++++++++
 3 files changed

// File: rtl/dac_spi_serializer_pkg.sv
// Shared constants and FSM encoding for the DAC SPI serializer and its frame shifter.
package dac_spi_serializer_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Counter width that stays legal when the count range collapses to a single value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dac_frame_shifter.sv
// Mode-0 SPI frame engine: chip-select framing, SCLK divider, bit counter and MSB-first shift register.
module dac_frame_shifter
  import dac_spi_serializer_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [FRAME_BITS-1:0] frame_i,
  output logic                  idle_o,
  output logic                  spi_cs_n_o,
  output logic                  spi_sclk_o,
  output logic                  spi_mosi_o
);

  localparam int               DIV_W    = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  state_e                state_q;
  logic [DIV_W-1:0]      div_q;
  logic [3:0]            bit_q;
  logic [FRAME_BITS-2:0] shreg_q;  // bits still to be presented after the MSB
  logic                  cs_n_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  div_done;

  assign div_done   = (div_q == DIV_LAST);
  assign idle_o     = (state_q == ST_IDLE);
  assign spi_cs_n_o = cs_n_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;

  // NOTE: every register here updates with <= so all reads see pre-edge values and
  // the block order does not matter; blocking writes would leak new values mid-block.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_i) begin
            shreg_q <= frame_i[FRAME_BITS-2:0];
            mosi_q  <= frame_i[FRAME_BITS-1];
            cs_n_q  <= 1'b0;
            div_q   <= '0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (div_done) begin
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!div_done) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (sclk_q) begin
              // Next bit goes out with the falling edge so it is stable for the whole low phase.
              sclk_q <= 1'b0;
              if (bit_q != BIT_LAST) begin
                mosi_q  <= shreg_q[FRAME_BITS-2];
                shreg_q <= {shreg_q[FRAME_BITS-3:0], 1'b0};
              end
            end else if (bit_q == BIT_LAST) begin
              cs_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
              state_q <= ST_HOLD;
            end else begin
              bit_q  <= bit_q + 4'd1;
              sclk_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (div_done) begin
            div_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dac_spi_serializer.sv
// Sample-to-DAC bridge: offset-binary conversion, one-deep holding register with sticky
// overflow, and a frame shifter that drives the SPI pins.
module dac_spi_serializer
  import dac_spi_serializer_pkg::*;
#(
  parameter int                  N_FRAC  = 7,
  parameter int                  CLK_DIV = 1,
  parameter logic [CMD_BITS-1:0] DAC_CMD = 4'b0011
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic [N_FRAC:0] data_i,
  input  logic          data_valid_strobe_i,
  input  logic          clear_overflow_i,
  output logic          spi_cs_n_o,
  output logic          spi_sclk_o,
  output logic          spi_mosi_o,
  output logic          busy_o,
  output logic          overflow_o
);

  localparam int SAMPLE_W = N_FRAC + 1;
  localparam int PAD_W    = FRAME_BITS - CMD_BITS - SAMPLE_W;

  logic [SAMPLE_W-1:0]   hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  overflow_q, overflow_d;
  logic                  accept;
  logic                  load;
  logic                  fsm_idle;
  logic [FRAME_BITS-1:0] frame;

  assign accept = enable_i & data_valid_strobe_i;
  assign load   = fsm_idle & hold_full_q;
  assign frame  = FRAME_BITS'({DAC_CMD, hold_q}) << PAD_W;

  // NOTE: each next-state signal gets its hold value first so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q & ~load;
    overflow_d  = overflow_q & ~clear_overflow_i;
    if (accept) begin
      hold_d      = {~data_i[N_FRAC], data_i[N_FRAC-1:0]};
      hold_full_d = 1'b1;
      // Overwrite of an unsent sample wins over a same-cycle clear.
      if (hold_full_q & ~load) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overflow_q  <= overflow_d;
    end
  end

  dac_frame_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .frame_i    (frame),
    .idle_o     (fsm_idle),
    .spi_cs_n_o (spi_cs_n_o),
    .spi_sclk_o (spi_sclk_o),
    .spi_mosi_o (spi_mosi_o)
  );

  assign busy_o     = ~fsm_idle | hold_full_q;
  assign overflow_o = overflow_q;

endmodule
